// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array feeder.
//   feeder_state_t : beat-intake FSM states
//   CTRL_W         : sideband bits that travel with each column lane
//                    (valid, propagate, dataflow)
//   clog2()        : ceiling log2 for sizing counters from parameters
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    localparam int CTRL_W = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-latency delay line used for one skew lane.
//   clock, reset : clock and synchronous active-high reset (clears all taps)
//   din          : lane value entering the pipe
//   dout         : din delayed by DEPTH cycles (DEPTH = 0 is a plain wire)
module skew_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] taps [DEPTH];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
            end else begin
                taps[0] <= din;
                for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            end
        end

        assign dout = taps[DEPTH-1];
    end

endmodule

// File: rtl/sys_array_feeder.sv
// Upstream feeder for the systolic mesh: accepts one unskewed beat per
// cycle, applies triangular skew (row lane r and column lane c delayed by
// r and c cycles), tags each matrix with a toggling propagate bit and
// drains the skew pipe between matrices.
//
// State table:
//   IDLE   | waiting for the first beat of a matrix, in_ready high
//   STREAM | matrix in progress, in_ready high
//   DRAIN  | last beat taken, in_ready low while the skew pipe empties
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   in_valid / in_ready   : beat handshake
//   in_last               : final beat of the current matrix
//   in_dataflow           : dataflow mode, sampled on a matrix's first beat
//   in_a / in_b / in_d    : unskewed lane slices, lane 0 in the LSBs
//   out_a / out_b / out_d : skewed slices to the mesh edges
//   out_dataflow, out_propagate, out_valid : per-column skewed sideband
//   busy                  : high in STREAM or DRAIN
//   beat_count            : beats accepted in the current matrix (saturating)
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int BITWIDTH = 8,
    parameter int MAXBEATS = 256
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic                           in_dataflow,
    input  logic [ROWS*BITWIDTH-1:0]       in_a,
    input  logic [COLS*BITWIDTH-1:0]       in_b,
    input  logic [COLS*BITWIDTH-1:0]       in_d,
    output logic [ROWS*BITWIDTH-1:0]       out_a,
    output logic [COLS*BITWIDTH-1:0]       out_b,
    output logic [COLS*BITWIDTH-1:0]       out_d,
    output logic [COLS-1:0]                out_dataflow,
    output logic [COLS-1:0]                out_propagate,
    output logic [COLS-1:0]                out_valid,
    output logic                           busy,
    output logic [clog2(MAXBEATS+1)-1:0]   beat_count
);

    localparam int DEPTH_MAX = (ROWS > COLS) ? ROWS : COLS;
    localparam int DRAIN_LEN = DEPTH_MAX - 1;
    localparam int DCW       = (clog2(DEPTH_MAX) > 0) ? clog2(DEPTH_MAX) : 1;
    localparam int BCW       = clog2(MAXBEATS + 1);
    localparam int COL_W     = 2 * BITWIDTH + CTRL_W;

    feeder_state_t  state, state_next;
    logic [DCW-1:0] drain_cnt, drain_cnt_next;
    logic           accept, first_beat, drain_done;
    logic           prop_flag, dataflow_q;
    logic           stage_prop, stage_dataflow;
    feeder_state_t  end_state;

    // Reset gates acceptance so the combinational lane 0 stays quiet while
    // reset is held.
    assign in_ready   = (state != DRAIN);
    assign accept     = in_valid & in_ready & ~reset;
    assign first_beat = accept & (state == IDLE);
    assign busy       = (state != IDLE);
    assign end_state  = (DRAIN_LEN == 0) ? IDLE : DRAIN;
    assign drain_done = (state == DRAIN) && (drain_cnt == '0);

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            IDLE: begin
                if (accept) state_next = in_last ? end_state : STREAM;
            end
            STREAM: begin
                if (accept && in_last) state_next = end_state;
            end
            DRAIN: begin
                if (drain_cnt == '0) state_next = IDLE;
                else                 drain_cnt_next = drain_cnt - DCW'(1);
            end
            default: state_next = IDLE;
        endcase
        // Down-counter preloaded so DRAIN lasts exactly DRAIN_LEN cycles.
        if (accept && in_last && (DRAIN_LEN > 0)) drain_cnt_next = DCW'(DRAIN_LEN - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            prop_flag  <= 1'b0;
            dataflow_q <= 1'b0;
            beat_count <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            if (first_beat) begin
                prop_flag  <= ~prop_flag;
                dataflow_q <= in_dataflow;
            end
            if (accept) begin
                if (first_beat)                          beat_count <= BCW'(1);
                else if (beat_count != BCW'(MAXBEATS))   beat_count <= beat_count + BCW'(1);
            end else if (drain_done) begin
                beat_count <= '0;
            end
        end
    end

    // The new matrix's propagate value must already be visible on its first
    // beat, so it bypasses the flag register; otherwise both sideband bits
    // hold so the mesh never sees a spurious toggle in a gap.
    assign stage_prop     = first_beat ? ~prop_flag  : prop_flag;
    assign stage_dataflow = first_beat ? in_dataflow : dataflow_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [BITWIDTH-1:0] row_in;
        assign row_in = accept ? in_a[r*BITWIDTH +: BITWIDTH] : '0;
        skew_delay #(.WIDTH(BITWIDTH), .DEPTH(r)) u_skew (
            .clock (clock),
            .reset (reset),
            .din   (row_in),
            .dout  (out_a[r*BITWIDTH +: BITWIDTH])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [COL_W-1:0] col_in, col_out;
        assign col_in = {accept, stage_prop, stage_dataflow,
                         accept ? in_d[c*BITWIDTH +: BITWIDTH] : {BITWIDTH{1'b0}},
                         accept ? in_b[c*BITWIDTH +: BITWIDTH] : {BITWIDTH{1'b0}}};
        skew_delay #(.WIDTH(COL_W), .DEPTH(c)) u_skew (
            .clock (clock),
            .reset (reset),
            .din   (col_in),
            .dout  (col_out)
        );
        assign out_b[c*BITWIDTH +: BITWIDTH] = col_out[BITWIDTH-1:0];
        assign out_d[c*BITWIDTH +: BITWIDTH] = col_out[2*BITWIDTH-1:BITWIDTH];
        assign out_dataflow[c]               = col_out[2*BITWIDTH];
        assign out_propagate[c]              = col_out[2*BITWIDTH+1];
        assign out_valid[c]                  = col_out[2*BITWIDTH+2];
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Self-checking bench for sys_array_feeder. The reference model keeps a
// per-cycle history of what the feeder should have accepted and derives
// each output lane k as the history entry from k cycles earlier; the FSM
// is modelled as "matrix open" plus "drain cycles remaining".
module tb_sys_array_feeder;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int BW        = 8;
    localparam int MB        = 256;
    localparam int MB_S      = 2;
    localparam int BCW       = 9;
    localparam int BCW_S     = 2;
    localparam int DRAIN_LEN = 3;
    localparam int L         = ROWS*BW + 2*COLS*BW + 3*COLS + 2;
    localparam int OBS_W     = 2*L + BCW + BCW_S;
    localparam int HN        = 2048;

    logic clock = 1'b0;
    logic reset, in_valid, in_last, in_dataflow;
    logic [ROWS*BW-1:0] in_a;
    logic [COLS*BW-1:0] in_b, in_d;

    logic               in_ready, busy, in_ready_s, busy_s;
    logic [ROWS*BW-1:0] out_a, out_a_s;
    logic [COLS*BW-1:0] out_b, out_d, out_b_s, out_d_s;
    logic [COLS-1:0]    out_dataflow, out_propagate, out_valid;
    logic [COLS-1:0]    out_dataflow_s, out_propagate_s, out_valid_s;
    logic [BCW-1:0]     beat_count;
    logic [BCW_S-1:0]   beat_count_s;

    sys_array_feeder #(.ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW), .MAXBEATS(MB)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_dataflow(in_dataflow), .in_a(in_a), .in_b(in_b), .in_d(in_d),
        .out_a(out_a), .out_b(out_b), .out_d(out_d), .out_dataflow(out_dataflow),
        .out_propagate(out_propagate), .out_valid(out_valid), .busy(busy), .beat_count(beat_count)
    );

    sys_array_feeder #(.ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW), .MAXBEATS(MB_S)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .in_dataflow(in_dataflow), .in_a(in_a), .in_b(in_b), .in_d(in_d),
        .out_a(out_a_s), .out_b(out_b_s), .out_d(out_d_s), .out_dataflow(out_dataflow_s),
        .out_propagate(out_propagate_s), .out_valid(out_valid_s), .busy(busy_s),
        .beat_count(beat_count_s)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int t = 0;
    int rst_cyc = -1;
    int drain_left = 0;
    int bc = 0;
    int bc_s = 0;
    int exp_ovr = 0;
    int obs_ovr = 0;
    bit open = 0, mprop = 0, mdf = 0;
    bit cur_acc, cur_first, cur_last, cur_f;

    logic               hv [HN];
    logic               hp [HN];
    logic               hf [HN];
    logic [ROWS*BW-1:0] ha [HN];
    logic [COLS*BW-1:0] hb [HN];
    logic [COLS*BW-1:0] hd [HN];

    // overrun monitor on the MAXBEATS=2 instance
    always @(negedge clock)
        if (!reset && in_valid && in_ready_s && beat_count_s == BCW_S'(MB_S)) obs_ovr++;

    function automatic logic [OBS_W-1:0] observe();
        return {out_a, out_b, out_d, out_valid, out_propagate, out_dataflow, in_ready, busy, beat_count,
                out_a_s, out_b_s, out_d_s, out_valid_s, out_propagate_s, out_dataflow_s,
                in_ready_s, busy_s, beat_count_s};
    endfunction

    function automatic logic [OBS_W-1:0] expect_now();
        logic [ROWS*BW-1:0] ea;
        logic [COLS*BW-1:0] eb, ed;
        logic [COLS-1:0]    ev, ep, ef;
        logic               er, eb_busy;
        int idx;
        ea = '0; eb = '0; ed = '0; ev = '0; ep = '0; ef = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = t - r;
            if (idx > rst_cyc && idx >= 0) ea[r*BW +: BW] = ha[idx][r*BW +: BW];
        end
        for (int c = 0; c < COLS; c++) begin
            idx = t - c;
            if (idx > rst_cyc && idx >= 0) begin
                eb[c*BW +: BW] = hb[idx][c*BW +: BW];
                ed[c*BW +: BW] = hd[idx][c*BW +: BW];
                ev[c] = hv[idx];
                ep[c] = hp[idx];
                ef[c] = hf[idx];
            end
        end
        er      = (drain_left == 0);
        eb_busy = open || (drain_left > 0);
        return {ea, eb, ed, ev, ep, ef, er, eb_busy, BCW'(bc),
                ea, eb, ed, ev, ep, ef, er, eb_busy, BCW_S'(bc_s)};
    endfunction

    task automatic drive(input logic rst, input logic v, input logic last, input logic df,
                         input logic [ROWS*BW-1:0] a, input logic [COLS*BW-1:0] b,
                         input logic [COLS*BW-1:0] d);
        reset = rst; in_valid = v; in_last = last; in_dataflow = df;
        in_a = a; in_b = b; in_d = d;
        cur_acc   = v && !rst && (drain_left == 0);
        cur_first = cur_acc && !open;
        cur_last  = last;
        cur_f     = cur_first ? df : mdf;
        hv[t] = cur_acc;
        hp[t] = cur_first ? !mprop : mprop;
        hf[t] = cur_f;
        ha[t] = cur_acc ? a : '0;
        hb[t] = cur_acc ? b : '0;
        hd[t] = cur_acc ? d : '0;
        if (cur_acc && bc_s == MB_S) exp_ovr++;
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            open = 0; drain_left = 0; mprop = 0; mdf = 0; bc = 0; bc_s = 0; rst_cyc = t;
        end else if (cur_acc) begin
            if (cur_first) begin
                mprop = !mprop; mdf = cur_f; bc = 1; bc_s = 1;
            end else begin
                if (bc < MB) bc++;
                if (bc_s < MB_S) bc_s++;
            end
            if (cur_last) begin open = 0; drain_left = DRAIN_LEN; end
            else open = 1;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) begin bc = 0; bc_s = 0; end
        end
        t++;
        #1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, '0, '0, '0);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL %s idle t=%0d got=%h want=%h", tag, t, observe(), expect_now());
            end
            advance();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 1, $urandom, $urandom, $urandom);
            advance();
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if ({out_a, out_b, out_d, out_valid, out_propagate, out_dataflow, busy, beat_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", {out_a, out_b, out_d, out_valid, out_propagate, out_dataflow, busy, beat_count});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
        advance();
    endtask

    task automatic test_three_beats();
        logic [ROWS*BW-1:0] a;
        logic [COLS*BW-1:0] b, d;
        for (int beat = 0; beat < 3; beat++) begin
            for (int r = 0; r < ROWS; r++) a[r*BW +: BW] = BW'(beat*10 + r);
            for (int c = 0; c < COLS; c++) begin
                b[c*BW +: BW] = BW'(beat*10 + c);
                d[c*BW +: BW] = BW'(100 + beat*10 + c);
            end
            drive(0, 1, beat == 2, 0, a, b, d);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL three_beats t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            advance();
        end
        // DRAIN: valid held high but must be refused for three cycles
        for (int i = 0; i < DRAIN_LEN; i++) begin
            drive(0, 1, 0, 0, $urandom, $urandom, $urandom);
            @(negedge clock);
            n_cmp++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL three_beats_drain t=%0d ready=%b busy=%b want ready=0 busy=1", t, in_ready, busy);
            end
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL three_beats_drain_model t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            advance();
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || beat_count !== '0) begin
            n_fail++;
            $display("FAIL three_beats_end busy=%b count=%0d want busy=0 count=0", busy, beat_count);
        end
        advance();
        idle_cycles(2, "three_beats");
    endtask

    task automatic test_back_to_back();
        int n1, n2, idx, budget;
        n1 = $urandom_range(2, 4);
        n2 = $urandom_range(2, 4);
        idx = 0;
        budget = 0;
        while (idx < n1 + n2 && budget < 40) begin
            drive(0, 1, (idx == n1 - 1) || (idx == n1 + n2 - 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            if (cur_acc) idx++;
            advance();
            budget++;
        end
        n_cmp++;
        if (idx != n1 + n2) begin
            n_fail++;
            $display("FAIL back_to_back_timeout accepted=%0d want=%0d", idx, n1 + n2);
        end
        idle_cycles(7, "back_to_back");
    endtask

    task automatic test_single_beat();
        drive(0, 1, 1, 1, $urandom, $urandom, $urandom);
        @(negedge clock);
        n_cmp++;
        if (observe() !== expect_now()) begin
            n_fail++;
            $display("FAIL single_beat t=%0d got=%h want=%h", t, observe(), expect_now());
        end
        advance();
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if (beat_count !== BCW'(1) || out_dataflow[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat_count count=%0d df1=%b want count=1 df1=1", beat_count, out_dataflow[1]);
        end
        advance();
        idle_cycles(5, "single_beat");
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if (beat_count !== '0) begin
            n_fail++;
            $display("FAIL single_beat_clear count=%0d want=0", beat_count);
        end
        advance();
    endtask

    task automatic test_gaps();
        logic pattern [4];
        pattern[0] = 1; pattern[1] = 0; pattern[2] = 1; pattern[3] = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, pattern[i], i == 3, $urandom_range(0, 1), $urandom, $urandom, $urandom);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL gaps t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            advance();
        end
        idle_cycles(6, "gaps");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, $urandom, $urandom, $urandom);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL reset_mid_stream t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            advance();
        end
        drive(1, 1, 0, 1, $urandom, $urandom, $urandom);
        advance();
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if ({out_a, out_b, out_d, out_valid, out_propagate, out_dataflow, busy, beat_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_flush got=%h want=0", {out_a, out_b, out_d, out_valid, out_propagate, out_dataflow, busy, beat_count});
        end
        advance();
        drive(0, 1, 1, 0, $urandom, $urandom, $urandom);
        @(negedge clock);
        n_cmp++;
        if (out_propagate[0] !== 1'b1 || out_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_prop prop0=%b valid0=%b want 1 1", out_propagate[0], out_valid[0]);
        end
        advance();
        idle_cycles(5, "reset_mid");
    endtask

    task automatic test_overrun();
        int ovr_before_obs, ovr_before_exp;
        ovr_before_obs = obs_ovr;
        ovr_before_exp = exp_ovr;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i == 2, 0, $urandom, $urandom, $urandom);
            @(negedge clock);
            n_cmp++;
            if (observe() !== expect_now()) begin
                n_fail++;
                $display("FAIL overrun t=%0d got=%h want=%h", t, observe(), expect_now());
            end
            advance();
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clock);
        n_cmp++;
        if (beat_count_s !== BCW_S'(MB_S) || beat_count !== BCW'(3)) begin
            n_fail++;
            $display("FAIL overrun_count small=%0d big=%0d want small=2 big=3", beat_count_s, beat_count);
        end
        n_cmp++;
        if (obs_ovr - ovr_before_obs != 1 || exp_ovr - ovr_before_exp != 1) begin
            n_fail++;
            $display("FAIL overrun_event seen=%0d want=1", obs_ovr - ovr_before_obs);
        end
        advance();
        idle_cycles(5, "overrun");
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom, $urandom, $urandom);
            @(negedge clock);
            if (!reset) begin
                n_cmp++;
                if (observe() !== expect_now()) begin
                    n_fail++;
                    $display("FAIL random t=%0d got=%h want=%h", t, observe(), expect_now());
                end
            end
            advance();
        end
        idle_cycles(5, "random");
        n_cmp++;
        if (obs_ovr != exp_ovr) begin
            n_fail++;
            $display("FAIL random_overrun_total seen=%0d want=%0d", obs_ovr, exp_ovr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d want completion", t);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; in_valid = 0; in_last = 0; in_dataflow = 0;
        in_a = '0; in_b = '0; in_d = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_three_beats();
        test_back_to_back();
        test_single_beat();
        test_gaps();
        test_reset_mid();
        test_overrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
- Upstream stage of the systolic mesh. It takes one unskewed beat per cycle: an A row-slice (one element per mesh row lane) plus B and D column-slices (one element per mesh column lane).
- It applies triangular skew: A lane r is delayed r cycles, and column lane c (B, D, dataflow, propagate, valid) is delayed c cycles. Each operand then reaches its PE on the correct wavefront.
- It generates the per-matrix propagate toggle and flushes the skew pipe between matrices.

Parameters:
- ROWS, 4, total row lanes (mesh rows × tile rows); ≥1
- COLS, 4, total column lanes (mesh cols × tile cols); ≥1
- BITWIDTH, 8, signed element width
- MAXBEATS, 256, maximum beats per matrix; sets the beat counter width to clog2(MAXBEATS+1)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  feeder accepts a beat this cycle
- in_last  in  1  final beat of the current matrix
- in_dataflow  in  1  dataflow mode for the matrix; sampled on the first beat
- in_a  in  ROWS*BITWIDTH  A slice, lane r at [r*BITWIDTH +: BITWIDTH]
- in_b  in  COLS*BITWIDTH  B slice, same packing
- in_d  in  COLS*BITWIDTH  D (bias/partial) slice
- out_a  out  ROWS*BITWIDTH  skewed A to mesh west edge
- out_b  out  COLS*BITWIDTH  skewed B to mesh north edge
- out_d  out  COLS*BITWIDTH  skewed D
- out_dataflow  out  COLS  per-column skewed dataflow
- out_propagate  out  COLS  per-column skewed propagate
- out_valid  out  COLS  per-column skewed valid
- busy  out  1  high in STREAM or DRAIN
- beat_count  out  clog2(MAXBEATS+1)  beats accepted in the current matrix

Behaviour:
- FSM states: IDLE, STREAM, DRAIN. Reset → IDLE.
  - IDLE: in_ready=1. An accepted beat (in_valid & in_ready) → STREAM, or → DRAIN if in_last is also set.
  - STREAM: in_ready=1. An accepted beat with in_last → DRAIN.
  - DRAIN: in_ready=0 for exactly max(ROWS,COLS)-1 cycles, counted by drain_cnt, then → IDLE. If max(ROWS,COLS)=1, DRAIN lasts 0 cycles (go straight to IDLE).
- Matrix boundary:
  - prop_flag register, reset 0, toggles on the first accepted beat taken in IDLE.
  - The toggled value applies to that beat and every beat of the matrix.
  - dataflow is latched on that same beat.
- Skew stage input (lane 0 of each pipe):
  - Accepted beat: data = in_*, valid = 1, propagate = prop_flag (new value), dataflow = latched value.
  - Any other cycle: data = 0, valid = 0; propagate and dataflow hold their last values, so the mesh never sees a spurious toggle.
- Skew pipes:
  - Lane k has k registers. Lane 0 is combinational from the stage input, so out lane 0 has 0-cycle latency and lane k has k-cycle latency.
  - The pipes advance every cycle; there is no stall, because the mesh has no backpressure.
- Reset values: all skew registers, out_*, beat_count, busy, and prop_flag are 0.
- beat_count:
  - Increments on each accepted beat and saturates at MAXBEATS.
  - Clears to 0 on entry to IDLE from DRAIN.
  - A beat accepted in IDLE loads 1.
- Beat overrun: an accepted beat when beat_count==MAXBEATS is still forwarded. This condition is an assertion target; it is not corrected in hardware.
- Simultaneous events:
  - in_last on the first beat → one-beat matrix; DRAIN follows.
  - in_valid during DRAIN is ignored, because in_ready=0.
- Reset mid-operation: all pipes flush to 0 and valid to 0 on the next edge; in-flight beats are lost; prop_flag returns to 0.
- Arithmetic: none on data; values pass bit-exact. Packing is LSB-lane-first.

Decomposition:
- Shared package sys_array_pkg:
  - state enum feeder_state_t {IDLE, STREAM, DRAIN}
  - lane-slice helper width constant
  - clog2 function
- One natural sub-module: skew_delay, parameterised by WIDTH and DEPTH (DEPTH=0 → wire). Instantiate it per lane from a generate loop.

Test Plan:
- ROWS=COLS=4; reset, then 3 beats with a lane value of beat*10+lane, last on beat 3 → lane k shows its values at cycles k..k+2; out_valid[k] high exactly those cycles; out_propagate all 1; then DRAIN 3 cycles with in_ready=0; busy falls after cycle 3+3.
- Two back-to-back matrices, held in_valid → second matrix is accepted only after DRAIN; out_propagate lanes flip 1→0 staggered one cycle per column; zero bubble overlap.
- Single-beat matrix with in_last on the first beat, in_dataflow=1 → out_dataflow[k]=1 at cycle k; beat_count=1; then returns to 0 after DRAIN.
- in_valid toggling 1,0,1,1 within a matrix → gaps propagate as valid=0, zero data in each lane with matching skew; propagate is held.
- Reset asserted mid-STREAM with lane 3 holding a beat → next cycle all outputs 0, state IDLE, prop_flag 0; the next matrix yields propagate=1.
- MAXBEATS=2, send 3 beats → beat_count saturates at 2; overrun assertion fires; the third beat still appears skewed.
